// File: rtl/histogram_readout_sequencer_if.sv
// Record stream from the readout sequencer to its consumer.
// A record transfers on a rising clk edge where out_valid && out_ready; while out_valid is
// high and out_ready is low, out_bin/out_count/out_last hold and out_valid stays high.
interface histogram_readout_sequencer_if #(
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 32
);
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_WIDTH-1:0]  out_bin;
  logic [COUNT_WIDTH-1:0] out_count;
  logic                   out_last;

  modport master (output out_valid, output out_bin, output out_count, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_bin, input  out_count, input  out_last,
                  output out_ready);
endinterface

// File: rtl/histogram_readout_sequencer.sv
// Blocks histogram acquisition, walks every bin, streams each count out and optionally
// clears it; strobes that arrive while acquisition is blocked are counted as dropped.
module histogram_readout_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int COUNT_WIDTH  = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear_after_read,
  input  logic                   acq_value_ready,
  output logic                   hist_value_ready,
  output logic [ADDR_WIDTH-1:0]  hist_read_address,
  input  logic [COUNT_WIDTH-1:0] hist_read_data,
  output logic                   hist_clear_en,
  histogram_readout_sequencer_if.master rec,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            dropped_events,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_READ    = 3'd2,
    S_PRESENT = 3'd3,
    S_CLEAR   = 3'd4,
    S_NEXT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int LW = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [LW-1:0]         LAT_END  = LW'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = '1;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [LW-1:0]          lat_cnt;
  logic                   clear_q;
  logic                   acq_prev;
  logic [15:0]            dropped_q;
  logic                   blocked;
  logic                   valid;

  always_ff @(posedge clk) begin
    acq_prev <= acq_value_ready;
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      count_q   <= '0;
      lat_cnt   <= '0;
      clear_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        clear_q <= clear_after_read;
        addr    <= '0;
      end
      // Data for the held address is valid READ_LATENCY clocks after it changed.
      if (state == S_READ) begin
        if (lat_cnt == LAT_END) begin
          count_q <= hist_read_data;
          lat_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
      if (state == S_NEXT && addr != LAST_BIN) addr <= addr + 1'b1;
      if (blocked && acq_value_ready && !acq_prev && dropped_q != 16'hFFFF)
        dropped_q <= dropped_q + 16'd1;
    end
  end

  always_comb begin
    state_nx         = state;
    hist_value_ready = 1'b0;
    hist_clear_en    = 1'b0;
    valid            = 1'b0;
    done             = 1'b0;
    blocked          = 1'b0;
    busy             = 1'b0;
    // Reset outputs take effect in the cycle reset is seen, so a clear in flight is suppressed.
    if (reset) begin
      hist_value_ready = acq_value_ready;
    end else begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          hist_value_ready = acq_value_ready;
          if (start) state_nx = S_DRAIN;
        end
        S_DRAIN: begin
          hist_value_ready = acq_value_ready;
          if (!acq_value_ready) state_nx = S_READ;
        end
        S_READ: begin
          blocked = 1'b1;
          if (lat_cnt == LAT_END) state_nx = S_PRESENT;
        end
        S_PRESENT: begin
          blocked = 1'b1;
          valid   = 1'b1;
          if (rec.out_ready) state_nx = clear_q ? S_CLEAR : S_NEXT;
        end
        S_CLEAR: begin
          blocked       = 1'b1;
          hist_clear_en = 1'b1;
          state_nx      = S_NEXT;
        end
        S_NEXT: begin
          blocked  = 1'b1;
          state_nx = (addr == LAST_BIN) ? S_DONE : S_READ;
        end
        S_DONE: begin
          blocked  = 1'b1;
          done     = 1'b1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign hist_read_address = addr;
  assign rec.out_valid     = valid;
  assign rec.out_bin       = addr;
  assign rec.out_count     = count_q;
  assign rec.out_last      = valid && (addr == LAST_BIN);
  assign dropped_events    = dropped_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_histogram_readout_sequencer.sv
// Bench for histogram_readout_sequencer: a histogram memory model with read latency, an
// expected-record queue filled at each start and a monitor that checks every accepted record.
module tb_histogram_readout_sequencer;
  localparam int AW  = 10;
  localparam int CW  = 32;
  localparam int LAT = 2;
  localparam int NB  = 1 << AW;
  localparam int RW  = AW + CW + 1;

  logic           clk = 1'b0;
  logic           reset, start, clear_after_read, acq_value_ready;
  logic           hist_value_ready, hist_clear_en, busy, done;
  logic [AW-1:0]  hist_read_address;
  logic [CW-1:0]  hist_read_data;
  logic [15:0]    dropped_events;
  logic [2:0]     state_dbg;

  histogram_readout_sequencer_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) rec ();

  histogram_readout_sequencer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .READ_LATENCY(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .clear_after_read  (clear_after_read),
    .acq_value_ready   (acq_value_ready),
    .hist_value_ready  (hist_value_ready),
    .hist_read_address (hist_read_address),
    .hist_read_data    (hist_read_data),
    .hist_clear_en     (hist_clear_en),
    .rec               (rec),
    .busy              (busy),
    .done              (done),
    .dropped_events    (dropped_events),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- histogram memory model ----------------
  logic [CW-1:0] hmem    [NB];
  logic [CW-1:0] pre_val [NB];
  logic [CW-1:0] ref_mem [NB];
  logic [CW-1:0] rd_pipe [LAT];
  logic          preload_req;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < NB; i++) hmem[i] <= pre_val[i];
    end else if (hist_clear_en) begin
      hmem[hist_read_address] <= '0;
    end
    rd_pipe[0] <= hmem[hist_read_address];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign hist_read_data = rd_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  string         nm_q[$];
  longint        act_q[$];
  longint        req_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            done_cnt = 0;
  int            clr_cnt  = 0;
  logic          stall_q = 1'b0;
  logic [RW-1:0] stall_rec, mon_got, mon_want;
  string         mon_nm;
  longint        mon_a, mon_e;

  always @(negedge clk) begin
    while (nm_q.size() > 0) begin
      mon_nm = nm_q.pop_front();
      mon_a  = act_q.pop_front();
      mon_e  = req_q.pop_front();
      n_tests++;
      if (mon_a != mon_e) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", mon_nm, mon_a, mon_e);
      end
    end
    mon_got = {rec.out_bin, rec.out_count, rec.out_last};
    if (reset) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_tests++;
        if (!rec.out_valid || mon_got != stall_rec) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0d rec=%h, expected valid=1 rec=%h",
                   rec.out_valid, mon_got, stall_rec);
        end
      end
      if (done) done_cnt++;
      if (hist_clear_en) clr_cnt++;
      if (rec.out_valid && rec.out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL record_extra: got bin=%0d count=%0d, expected no record",
                   rec.out_bin, rec.out_count);
        end else begin
          mon_want = exp_q.pop_front();
          if (mon_got != mon_want) begin
            n_fail++;
            $display("FAIL record: got bin=%0d count=%0d last=%0d, expected bin=%0d count=%0d last=%0d",
                     mon_got[RW-1 -: AW], mon_got[CW:1], mon_got[0],
                     mon_want[RW-1 -: AW], mon_want[CW:1], mon_want[0]);
          end
        end
      end
      stall_q   = rec.out_valid && !rec.out_ready;
      stall_rec = mon_got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input longint act, input longint req);
    nm_q.push_back(nm);
    act_q.push_back(act);
    req_q.push_back(req);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_preload(input bit rnd);
    for (int i = 0; i < NB; i++) begin
      pre_val[i] = rnd ? CW'($urandom) : CW'(3 * i);
      ref_mem[i] = pre_val[i];
    end
    preload_req = 1'b1;
    cyc(1);
    preload_req = 1'b0;
    cyc(1);
  endtask

  task automatic push_scan();
    for (int i = 0; i < NB; i++)
      exp_q.push_back({AW'(i), ref_mem[i], (i == NB - 1)});
  endtask

  task automatic issue_start(input bit clr);
    start            = 1'b1;
    clear_after_read = clr;
    push_scan();
    cyc(1);
    start            = 1'b0;
    clear_after_read = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      if (rnd) rec.out_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      seen = done;
      @(posedge clk);
      #1;
    end
    if (!seen) chk("scan_timeout", 0, 1);
    rec.out_ready = 1'b1;
    @(negedge clk);
    chk("busy_after_done", longint'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem();
    for (int i = 0; i < NB; i++)
      chk($sformatf("mem_bin%0d", i), longint'(hmem[i]), longint'(ref_mem[i]));
  endtask

  task automatic scan_end_checks(input int d0, input int c0, input int clears);
    cyc(2);
    chk("done_pulses", done_cnt - d0, 1);
    chk("clear_pulses", clr_cnt - c0, clears);
    chk("records_left", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, c0, hv, leak;
    bit hit;
    reset = 1'b1; start = 1'b0; clear_after_read = 1'b0;
    acq_value_ready = 1'b1; rec.out_ready = 1'b0; preload_req = 1'b0;

    // reset state with the strobe high
    cyc(3);
    @(negedge clk);
    chk("rst_hvr", hist_value_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rec.out_valid, 0);
    chk("rst_dropped", dropped_events, 0);
    chk("rst_done", done, 0);
    chk("rst_clear_en", hist_clear_en, 0);
    @(posedge clk); #1;
    acq_value_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hvr_follow", hist_value_ready, 0);
    @(posedge clk); #1;

    // full scan, no clear, consumer always ready
    do_preload(1'b0);
    rec.out_ready = 1'b1;
    d0 = done_cnt; c0 = clr_cnt;
    issue_start(1'b0);
    wait_done(20000, 1'b0);
    scan_end_checks(d0, c0, 0);
    check_mem();

    // full scan with clear
    do_preload(1'b0);
    d0 = done_cnt; c0 = clr_cnt;
    issue_start(1'b1);
    wait_done(20000, 1'b0);
    scan_end_checks(d0, c0, NB);
    for (int i = 0; i < NB; i++) ref_mem[i] = '0;
    check_mem();

    // random data, random backpressure, a start with clear while busy is ignored
    do_preload(1'b1);
    d0 = done_cnt; c0 = clr_cnt;
    issue_start(1'b0);
    for (int k = 0; k < 100; k++) begin
      rec.out_ready = ($urandom_range(0, 99) < 30);
      cyc(1);
    end
    start = 1'b1; clear_after_read = 1'b1;
    cyc(1);
    start = 1'b0; clear_after_read = 1'b0;
    wait_done(20000, 1'b1);
    scan_end_checks(d0, c0, 0);
    check_mem();

    // start in the middle of a 50-cycle strobe, then 5 strobes during the scan
    do_preload(1'b0);
    d0 = done_cnt; c0 = clr_cnt;
    acq_value_ready = 1'b1;
    hv = 0;
    for (int k = 0; k < 50; k++) begin
      if (k == 10) begin
        start = 1'b1;
        push_scan();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hv += int'(hist_value_ready);
      @(posedge clk); #1;
    end
    start = 1'b0;
    acq_value_ready = 1'b0;
    chk("strobe_intact", hv, 50);
    cyc(20);
    leak = 0;
    for (int s = 0; s < 5; s++) begin
      acq_value_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (k == 4) acq_value_ready = 1'b0;
        @(negedge clk);
        leak += int'(hist_value_ready);
        @(posedge clk); #1;
      end
    end
    chk("blocked_hvr", leak, 0);
    chk("busy_in_scan", busy, 1);
    wait_done(20000, 1'b0);
    scan_end_checks(d0, c0, 0);
    chk("dropped_events", dropped_events, 5);

    // reset at bin 500 of a clear scan, then restart
    do_preload(1'b0);
    issue_start(1'b1);
    hit = 1'b0;
    for (int c = 0; c < 20000 && !hit; c++) begin
      @(negedge clk);
      hit = rec.out_valid && (rec.out_bin == AW'(500));
      if (!hit) begin
        @(posedge clk); #1;
      end
    end
    if (!hit) chk("bin500_timeout", 0, 1);
    reset = 1'b1;
    for (int i = 0; i < 500; i++) ref_mem[i] = '0;
    cyc(2);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", rec.out_valid, 0);
    chk("abort_dropped", dropped_events, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);
    check_mem();
    d0 = done_cnt; c0 = clr_cnt;
    issue_start(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = rec.out_valid;
      @(posedge clk); #1;
    end
    chk("restart_first_valid", hit, 1);
    wait_done(20000, 1'b0);
    scan_end_checks(d0, c0, 0);
    check_mem();

    // report
    cyc(3);
    for (int c = 0; c < 10 && nm_q.size() > 0; c++) cyc(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
